// File: rtl/cobs_decode_stream.sv
// cobs_decode_stream: streaming COBS frame decoder with a one-byte hold so the final byte can carry o_last.
// Define COBS_DECODE_LEN_EN to add the per-frame length counter, o_len and overflow dropping.
module cobs_decode_stream #(
  parameter int MAX_FRAME = 1024,
  localparam int LW = $clog2(MAX_FRAME + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_last,
  output logic       o_error,
  output logic [1:0] o_err_code
`ifdef COBS_DECODE_LEN_EN
  ,
  output logic [LW-1:0] o_len
`endif
);
  if (MAX_FRAME < 2 || LW > 16) begin : g_bad_param
    $error("MAX_FRAME out of range");
  end
  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;
  state_t state, state_n;
  logic [7:0] rem, rem_n, hold, dec;
  logic pz, pz_n, hold_vld, hold_vld_n, accept, emit, load, load_last, err;
  logic [1:0] code_n;
`ifdef COBS_DECODE_LEN_EN
  logic [LW-1:0] cnt, cnt_n;
`endif
  assign o_ready = !o_valid || i_ready;
  assign accept = i_valid && o_ready;
  always_comb begin
    state_n = state;
    rem_n = rem;
    pz_n = pz;
    hold_vld_n = hold_vld;
    emit = 1'b0;
    dec = i_data;
    load_last = 1'b0;
    err = 1'b0;
    code_n = o_err_code;
    if (accept) begin
      if (state == DROP) state_n = i_data == 8'h00 ? IDLE : DROP;
      else if (i_data != 8'h00 && (state == IDLE || rem == 8'd0)) begin
        // code byte: the implicit zero of the previous block surfaces only now
        rem_n = i_data - 8'd1;
        pz_n = i_data != 8'hFF;
        state_n = DATA;
        emit = state == DATA && pz;
        dec = 8'h00;
      end else if (i_data != 8'h00) begin
        rem_n = rem - 8'd1;
        emit = 1'b1;
      end else if (state == DATA) begin
        state_n = IDLE;
        hold_vld_n = 1'b0;
        load_last = rem == 8'd0 && hold_vld;
        err = rem != 8'd0 || !hold_vld;
        code_n = !err ? o_err_code : rem != 8'd0 ? 2'd1 : 2'd3;
      end
    end
`ifdef COBS_DECODE_LEN_EN
    if (emit && cnt == LW'(MAX_FRAME)) begin
      emit = 1'b0;
      hold_vld_n = 1'b0;
      err = 1'b1;
      code_n = 2'd2;
      state_n = DROP;
    end
    cnt_n = state_n == DATA ? cnt + LW'(emit) : '0;
`endif
    load = emit ? hold_vld : load_last;
    if (emit) hold_vld_n = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= 8'd0;
      pz <= 1'b0;
      hold <= 8'd0;
      hold_vld <= 1'b0;
      o_data <= 8'd0;
      o_valid <= 1'b0;
      o_last <= 1'b0;
      o_error <= 1'b0;
      o_err_code <= 2'd0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      pz <= pz_n;
      hold_vld <= hold_vld_n;
      o_error <= err;
      o_err_code <= code_n;
      if (emit) hold <= dec;
      if (accept) begin
        o_valid <= load;
        o_last <= load_last;
        if (load) o_data <= hold;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_last <= 1'b0;
      end
    end
  end
`ifdef COBS_DECODE_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      o_len <= '0;
    end else begin
      cnt <= cnt_n;
      if (load_last) o_len <= cnt;
    end
  end
`endif
endmodule

// File: tb/tb_cobs_decode_stream.sv
// tb_cobs_decode_stream: vector table, corner sequences and random frames against a queue-based COBS model.
module tb_cobs_decode_stream;
`ifdef COBS_DECODE_LEN_EN
  localparam bit LEN_EN = 1'b1;
  localparam int MF = 4;
`else
  localparam bit LEN_EN = 1'b0;
  localparam int MF = 1024;
`endif
  localparam int LW = $clog2(MF + 1);
  typedef logic [7:0] bq_t[$];
  typedef logic [8:0] beat_q[$];
  typedef logic [1:0] code_q[$];
  typedef struct {
    int n;
    logic [95:0] in;
    int m;
    logic [63:0] out;
    logic [7:0] lastm;
    logic [1:0] err;
  } vec_t;
  logic clk, rst_n, i_valid, i_ready, o_ready, o_valid, o_last, o_error;
  logic [7:0] i_data, o_data;
  logic [1:0] o_err_code;
`ifdef COBS_DECODE_LEN_EN
  logic [LW-1:0] o_len;
`endif
  int checks = 0, errors = 0, rmode = 0;
  bit mon_en = 0, stalled = 0;
  logic [7:0] pd;
  logic pl;
  logic [1:0] last_code = 2'd0;
  beat_q got;
  code_q gerr;
  vec_t vt[8];
  cobs_decode_stream #(.MAX_FRAME(MF)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_error(o_error), .o_err_code(o_err_code)
`ifdef COBS_DECODE_LEN_EN
    , .o_len(o_len)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      i_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !i_ready : 1'($urandom_range(0, 1));
    end
  end
  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("o_ready_comb", int'(o_ready), int'(!o_valid || i_ready));
      if (stalled) chk("stall_hold", int'({o_valid, o_last, o_data}), int'({1'b1, pl, pd}));
      if (o_valid && i_ready) got.push_back({o_last, o_data});
      if (o_error) gerr.push_back(o_err_code);
      stalled = o_valid && !i_ready;
      pd = o_data;
      pl = o_last;
    end else stalled = 0;
  end
  task automatic send(input logic [7:0] b);
    bit acc = 0;
    i_data = b;
    i_valid = 1'b1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask
  task automatic run(input bq_t s, input int mode);
    bit idle = 0;
    got.delete();
    gerr.delete();
    rmode = mode;
    foreach (s[k]) send(s[k]);
    for (int t = 0; t < 200 && !idle; t++) begin
      @(negedge clk);
      idle = !o_valid;
    end
    if (!idle) chk("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
    rmode = 0;
  endtask
  task automatic compare(input string nm, input beat_q eb, input code_q ee);
    chk({nm, "_beats"}, got.size(), eb.size());
    for (int k = 0; k < eb.size() && k < got.size(); k++)
      chk($sformatf("%s_beat%0d", nm, k), int'(got[k]), int'(eb[k]));
    chk({nm, "_errs"}, gerr.size(), ee.size());
    for (int k = 0; k < ee.size() && k < gerr.size(); k++)
      chk($sformatf("%s_err%0d", nm, k), int'(gerr[k]), int'(ee[k]));
    if (ee.size() > 0) last_code = ee[ee.size()-1];
    chk({nm, "_code_held"}, int'(o_err_code), int'(last_code));
  endtask
  function automatic bq_t cobs_enc(input bq_t p);
    bq_t o;
    int ci = 0, code = 1;
    o.push_back(8'h00);
    foreach (p[k]) begin
      if (p[k] != 8'h00) begin
        o.push_back(p[k]);
        code++;
      end
      if (p[k] == 8'h00 || code == 255) begin
        o[ci] = 8'(code);
        ci = o.size();
        o.push_back(8'h00);
        code = 1;
      end
    end
    o[ci] = 8'(code);
    o.push_back(8'h00);
    return o;
  endfunction
  // Frame-buffer view: collect each frame's decoded bytes, then decide what survives at its end.
  task automatic model(input bq_t s, output beat_q eb, output code_q ee);
    bq_t fr;
    int mode = 0, rem = 0;
    bit pz = 0;
    logic [7:0] b;
    eb = {};
    ee = {};
    foreach (s[k]) begin
      b = s[k];
      if (mode == 2) begin
        if (b == 8'h00) mode = 0;
      end else if (mode == 0) begin
        if (b != 8'h00) begin
          fr = {};
          rem = int'(b) - 1;
          pz = b != 8'hFF;
          mode = 1;
        end
      end else if (b == 8'h00) begin
        if (rem > 0) begin
          for (int i = 0; i < fr.size() - 1; i++) eb.push_back({1'b0, fr[i]});
          ee.push_back(2'd1);
        end else if (fr.size() == 0) ee.push_back(2'd3);
        else for (int i = 0; i < fr.size(); i++) eb.push_back({i == fr.size() - 1, fr[i]});
        mode = 0;
      end else begin
        if (rem > 0) begin
          fr.push_back(b);
          rem--;
        end else begin
          if (pz) fr.push_back(8'h00);
          rem = int'(b) - 1;
          pz = b != 8'hFF;
        end
        if (LEN_EN && fr.size() > MF) begin
          for (int i = 0; i < MF - 1; i++) eb.push_back({1'b0, fr[i]});
          ee.push_back(2'd2);
          mode = 2;
        end
      end
    end
  endtask
  initial begin
    bq_t s, p;
    beat_q eb;
    code_q ee;
    int len, st;
    vt[0] = '{6, 96'h05_01_02_03_04_00, 4, 64'h01_02_03_04, 8'b1000, 2'd0};
    vt[1] = '{6, 96'h03_11_22_02_33_00, 4, 64'h11_22_00_33, 8'b1000, 2'd0};
    vt[2] = '{6, 96'h05_01_00_02_77_00, 1, 64'h77, 8'b0001, 2'd1};
    vt[3] = '{2, 96'h01_00, 0, 64'h0, 8'b0000, 2'd3};
    vt[4] = '{5, 96'h00_00_02_55_00, 1, 64'h55, 8'b0001, 2'd0};
    vt[5] = '{4, 96'h01_01_01_00, 2, 64'h00_00, 8'b0010, 2'd0};
    vt[6] = '{7, 96'h02_AA_00_03_BB_CC_00, 3, 64'hAA_BB_CC, 8'b0101, 2'd0};
    vt[7] = '{6, 96'h03_44_00_02_01_00, 1, 64'h01, 8'b0001, 2'd1};
    rst_n = 1'b1;
    i_valid = 1'b0;
    i_data = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_error", int'(o_error), 0);
    chk("rst_code", int'(o_err_code), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_ready", int'(o_ready), 1);
`ifdef COBS_DECODE_LEN_EN
    chk("rst_len", int'(o_len), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1;
    foreach (vt[v]) begin
      s = {};
      eb = {};
      ee = {};
      for (int k = 0; k < vt[v].n; k++) s.push_back(vt[v].in[8*(vt[v].n-1-k) +: 8]);
      for (int k = 0; k < vt[v].m; k++) eb.push_back({vt[v].lastm[k], vt[v].out[8*(vt[v].m-1-k) +: 8]});
      if (vt[v].err != 2'd0) ee.push_back(vt[v].err);
      run(s, 0);
      compare($sformatf("vec%0d", v), eb, ee);
    end
    s = {8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    eb = {9'h011, 9'h022, 9'h000, 9'h133};
    ee.delete();
    run(s, 1);
    compare("toggle", eb, ee);
`ifndef COBS_DECODE_LEN_EN
    s = {8'hFF};
    eb = {};
    for (int k = 1; k <= 254; k++) begin
      s.push_back(8'(k));
      eb.push_back({1'b0, 8'(k)});
    end
    s.push_back(8'h02);
    s.push_back(8'hAA);
    s.push_back(8'h00);
    eb.push_back(9'h1AA);
    run(s, 0);
    compare("long_ff", eb, ee);
`else
    s = {8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h02, 8'h09, 8'h00};
    eb = {9'h001, 9'h002, 9'h003, 9'h109};
    ee = {2'd2};
    run(s, 0);
    compare("overflow", eb, ee);
    chk("overflow_len", int'(o_len), 1);
`endif
    s = {8'h05, 8'h01, 8'h02};
    foreach (s[k]) send(s[k]);
    mon_en = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_code", int'(o_err_code), 0);
    chk("midrst_data", int'(o_data), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    last_code = 2'd0;
    mon_en = 1;
    s = {8'h02, 8'h66, 8'h00};
    eb = {9'h166};
    ee.delete();
    run(s, 0);
    compare("after_rst", eb, ee);
    for (int r = 0; r < 3; r++) begin
      s = {};
      for (int f = 0; f < 8; f++) begin
        p = {};
        len = LEN_EN ? $urandom_range(0, 7) : $urandom_range(0, 300);
        for (int k = 0; k < len; k++)
          p.push_back($urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom_range(1, 255)));
        st = s.size();
        s = {s, cobs_enc(p)};
        if ($urandom_range(0, 5) == 0 && s.size() - st > 3) s[st + $urandom_range(1, s.size() - st - 2)] = 8'h00;
        if ($urandom_range(0, 4) == 0) s.push_back(8'h00);
      end
      model(s, eb, ee);
      run(s, 2);
      compare($sformatf("rand%0d", r), eb, ee);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
